alu_arbiter: RTL and testbench

- Shares the single RV32 ALU between two requesters, e.g. requester 0 = execute path and requester 1 = address/CSR helper.
- Uses a valid/ready request handshake and a valid/ready response handshake.
- Arbitration is round-robin. Operands are registered before the ALU and the result is registered after it, so the ALU sees stable inputs for a full cycle.
- Sits between the requesters and the combinational ALU. Only this block drives the ALU inputs.

---
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational RV32 ALU between two requesters.
// Optional macro ALU_ARB_LOCK_EN adds req_lock[1:0] to pin grants to one owner.
module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [OP_W-1:0] req0_sel,
  input  logic [OP_W-1:0] req1_sel,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [XLEN-1:0] req1_b,
`ifdef ALU_ARB_LOCK_EN
  input  logic [1:0]      req_lock,
`endif
  output logic [1:0]      resp_valid,
  input  logic [1:0]      resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic [OP_W-1:0] alu_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [OP_W-1:0] sel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } alu_req_t;

  state_t   state;
  alu_req_t op_q, req_mux;
  logic     owner, last_grant, grant, gnt_vld, accept, legal;
`ifdef ALU_ARB_LOCK_EN
  logic     lock_q;
`endif

  // Legal set is 0..9 plus B_OUT (11); 10 and 12..15 are reserved.
  function automatic logic is_legal(input logic [OP_W-1:0] s);
    return (s <= OP_W'(9)) || (s == OP_W'(11));
  endfunction

  always_comb begin
    grant   = req_valid[1] & (~req_valid[0] | ~last_grant);
    gnt_vld = |req_valid;
`ifdef ALU_ARB_LOCK_EN
    if (lock_q) begin
      grant   = owner;
      gnt_vld = req_valid[owner];
    end
`endif
  end

  assign req_ready = (state == IDLE && gnt_vld) ? (2'b01 << grant) : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign req_mux   = grant ? alu_req_t'{req1_sel, req1_a, req1_b}
                           : alu_req_t'{req0_sel, req0_a, req0_b};
  assign legal     = is_legal(req_mux.sel);

  // ALU inputs come only from the operand regs, so they hold between ops.
  assign alu_sel = op_q.sel;
  assign alu_a   = op_q.a;
  assign alu_b   = op_q.b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      resp_valid <= 2'b00;
`ifdef ALU_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          owner <= grant;
`ifdef ALU_ARB_LOCK_EN
          lock_q <= req_lock[grant];
`endif
          if (legal) begin
            op_q       <= req_mux;
            last_grant <= grant;
            state      <= EXEC;
          end else begin
            // Illegal op skips the ALU entirely and reports straight away.
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 2'b01 << grant;
            state      <= RESP;
          end
        end
        EXEC: begin
          resp_data  <= alu_result;
          resp_err   <= 1'b0;
          resp_valid <= 2'b01 << owner;
          state      <= RESP;
        end
        RESP: if (resp_ready[owner]) begin
          resp_valid <= 2'b00;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus tie, backpressure, reset and lock sequences.
module tb_alu_arbiter;
  localparam int XLEN = 32;
  localparam int OP_W = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [OP_W-1:0] req0_sel = '0, req1_sel = '0;
  logic [XLEN-1:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
`ifdef ALU_ARB_LOCK_EN
  logic [1:0]      req_lock = '0;
`endif
  logic [1:0]      resp_valid;
  logic [1:0]      resp_ready = '0;
  logic [XLEN-1:0] resp_data;
  logic            resp_err;
  logic [OP_W-1:0] alu_sel;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;

  int n_chk = 0;
  int n_fail = 0;

  alu_arbiter #(.XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
`ifdef ALU_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Stand-in combinational RV32 ALU.
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      4'd0:  alu_result = alu_a + alu_b;
      4'd1:  alu_result = alu_a - alu_b;
      4'd2:  alu_result = alu_a << alu_b[4:0];
      4'd3:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd4:  alu_result = {31'b0, alu_a < alu_b};
      4'd5:  alu_result = alu_a ^ alu_b;
      4'd6:  alu_result = alu_a >> alu_b[4:0];
      4'd7:  alu_result = $signed(alu_a) >>> alu_b[4:0];
      4'd8:  alu_result = alu_a | alu_b;
      4'd9:  alu_result = alu_a & alu_b;
      4'd11: alu_result = alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int r, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin req0_sel = sel; req0_a = a; req0_b = b; end
    else        begin req1_sel = sel; req1_a = a; req1_b = b; end
    req_valid[r] = 1'b1;
  endtask

  // Wait (bounded) for req_ready[r], check it is one-hot, take the handshake edge.
  task automatic accept(input int r, input bit keep);
    int t = 0;
    while (!req_ready[r] && t < 20) begin @(negedge clk); #1; t++; end
    chk("accept_timeout", 32'(t < 20), 32'd1);
    chk("req_ready_onehot", 32'(req_ready), 32'(2'b01 << r));
    @(posedge clk); #1;
    if (!keep) req_valid[r] = 1'b0;
  endtask

  // Measure latency from the accept edge, check response, optionally stall, then consume.
  task automatic respond(input int r, input int lat, input logic [31:0] exp, input logic err, input int hold);
    int cyc = 0;
    do begin @(negedge clk); cyc++; end while (!resp_valid[r] && cyc < 10);
    chk("resp_latency", 32'(cyc), 32'(lat));
    chk("resp_valid", 32'(resp_valid), 32'(2'b01 << r));
    chk("resp_data", resp_data, exp);
    chk("resp_err", 32'(resp_err), 32'(err));
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      resp_ready[1-r] = 1'b1;
      @(negedge clk);
      chk("stall_data", resp_data, exp);
      chk("stall_valid", 32'(resp_valid), 32'(2'b01 << r));
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    resp_ready[1-r] = 1'b0;
    resp_ready[r] = 1'b1;
    @(posedge clk); #1;
    resp_ready[r] = 1'b0;
  endtask

  typedef struct {
    int          r;
    logic [3:0]  sel;
    logic [31:0] a, b, exp;
    logic        err;
  } vec_t;

  vec_t vecs[11];
  logic [3:0] prev_sel;

  initial begin
    vecs[0]  = '{0, 4'd0,  32'd5,          32'd7,      32'd12,         1'b0};
    vecs[1]  = '{1, 4'd1,  32'd10,         32'd3,      32'd7,          1'b0};
    vecs[2]  = '{0, 4'd2,  32'd1,          32'd4,      32'd16,         1'b0};
    vecs[3]  = '{1, 4'd3,  32'hFFFF_FFFF,  32'd1,      32'd1,          1'b0};
    vecs[4]  = '{0, 4'd4,  32'hFFFF_FFFF,  32'd1,      32'd0,          1'b0};
    vecs[5]  = '{1, 4'd7,  32'h8000_0000,  32'd4,      32'hF800_0000,  1'b0};
    vecs[6]  = '{0, 4'd9,  32'h0000_F0F0,  32'hFF00,   32'h0000_F000,  1'b0};
    vecs[7]  = '{1, 4'd11, 32'h123,        32'hABCD,   32'hABCD,       1'b0};
    vecs[8]  = '{1, 4'd10, 32'd9,          32'd9,      32'd0,          1'b1};
    vecs[9]  = '{0, 4'd15, 32'd1,          32'd2,      32'd0,          1'b1};
    vecs[10] = '{0, 4'd8,  32'h0F,         32'hF0,     32'hFF,         1'b0};

    // Reset state
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First tie after reset: requester 0 wins, requester 1 waits
    @(negedge clk);
    drive(0, 4'd1, 32'd10, 32'd3);
    drive(1, 4'd5, 32'hF0, 32'h0F);
    #1;
    accept(0, 1'b0);
    respond(0, 2, 32'd7, 1'b0, 0);
    accept(1, 1'b0);
    respond(1, 2, 32'hFF, 1'b0, 0);

    // Vector table
    prev_sel = 4'd5;
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].sel, vecs[i].a, vecs[i].b);
      #1;
      accept(vecs[i].r, 1'b0);
      respond(vecs[i].r, vecs[i].err ? 1 : 2, vecs[i].exp, vecs[i].err, 0);
      if (vecs[i].err) chk("illegal_alu_sel_held", 32'(alu_sel), 32'(prev_sel));
      else prev_sel = vecs[i].sel;
    end

    // Second tie after requester 0 was served last: requester 1 wins
    @(negedge clk);
    drive(0, 4'd0, 32'd1, 32'd2);
    drive(1, 4'd0, 32'd3, 32'd4);
    #1;
    accept(1, 1'b0);
    respond(1, 2, 32'd7, 1'b0, 0);
    accept(0, 1'b0);
    respond(0, 2, 32'd3, 1'b0, 0);

    // Backpressure: stalled SRA response, requester 1 held off, non-owner resp_ready ignored
    @(negedge clk);
    drive(0, 4'd7, 32'h8000_0000, 32'd4);
    #1;
    accept(0, 1'b0);
    drive(1, 4'd0, 32'd1, 32'd1);
    respond(0, 2, 32'hF800_0000, 1'b0, 3);
    accept(1, 1'b0);
    respond(1, 2, 32'd2, 1'b0, 0);

    // Reset asserted during EXEC
    @(negedge clk);
    drive(0, 4'd0, 32'd2, 32'd3);
    #1;
    accept(0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("exec_rst_alu_a", alu_a, 32'd0);
    chk("exec_rst_alu_b", alu_b, 32'd0);
    chk("exec_rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("exec_rst_resp_data", resp_data, 32'd0);
    chk("exec_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("exec_rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    drive(1, 4'd0, 32'd4, 32'd5);
    #1;
    accept(1, 1'b0);
    respond(1, 2, 32'd9, 1'b0, 0);

`ifdef ALU_ARB_LOCK_EN
    // Lock: requester 0 keeps the ALU for two ops while requester 1 waits
    @(negedge clk);
    drive(0, 4'd0, 32'd1, 32'd1);
    drive(1, 4'd0, 32'd100, 32'd1);
    req_lock = 2'b01;
    #1;
    accept(0, 1'b1);
    drive(0, 4'd1, 32'd5, 32'd2);
    req_lock = 2'b00;
    respond(0, 2, 32'd2, 1'b0, 0);
    accept(0, 1'b0);
    respond(0, 2, 32'd3, 1'b0, 0);
    accept(1, 1'b0);
    respond(1, 2, 32'd101, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
